// File: rtl/rv32_regfile.sv
// rtl/rv32_regfile.sv - RV32I two-read, one-write integer register file
//
// Ports:
//   clk                      rising-edge clock for all state
//   reset                    synchronous, active-high; clears every register
//   wr_en, wr_addr, wr_data  writeback port, committed at the rising edge
//   rd_en1, rd_addr1         read port 1 request
//   rd_data1                 read port 1 data (combinational)
//   rd_en2, rd_addr2         read port 2 request
//   rd_data2                 read port 2 data (combinational)

module rv32_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en1,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [DATA_WIDTH-1:0] rd_data1,
    input  logic                  rd_en2,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    // A write to x0 is dropped here so entry 0 only ever holds the reset
    // value; the read path additionally forces x0 to zero so it reads 0
    // even before the first reset edge.
    logic wr_commit;
    assign wr_commit = wr_en && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_commit) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Write-through bypass deliberately ignores reset: it depends only on the
    // current writeback inputs, so the writeback stage needs no extra
    // forwarding path.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic                  en,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  w_en,
        input logic [ADDR_WIDTH-1:0] w_addr,
        input logic [DATA_WIDTH-1:0] w_data,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] result;
        result = '0;
        if (en && (addr != '0)) begin
            if (w_en && (w_addr == addr)) begin
                result = w_data;
            end else begin
                result = stored;
            end
        end
        return result;
    endfunction

    always_comb begin
        rd_data1 = read_port(rd_en1, rd_addr1, wr_en, wr_addr, wr_data, regs_q[rd_addr1]);
        rd_data2 = read_port(rd_en2, rd_addr2, wr_en, wr_addr, wr_data, regs_q[rd_addr2]);
    end

endmodule

// File: tb/tb_rv32_regfile.sv
// tb/tb_rv32_regfile.sv - self-checking bench for rv32_regfile

module tb_rv32_regfile;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en1;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data1;
    logic        rd_en2;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data2;

    int tests_run;
    int tests_failed;

    rv32_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en1   (rd_en1),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .rd_en2   (rd_en2),
        .rd_addr2 (rd_addr2),
        .rd_data2 (rd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        e1;
        logic [4:0]  a1;
        logic        e2;
        logic [4:0]  a2;
        logic [31:0] x1;
        logic [31:0] x2;
        logic        clk_after;
    } vec_t;

    vec_t vecs[$];

    task automatic check_outputs();
        sb_entry_t e;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty: got %h/%h with no expectation queued", rd_data1, rd_data2);
        end else begin
            e = sb_q.pop_front();
            if (rd_data1 !== e.exp1 || rd_data2 !== e.exp2) begin
                tests_failed++;
                $display("FAIL %s: rd_data1=%h rd_data2=%h required %h %h",
                         e.name, rd_data1, rd_data2, e.exp1, e.exp2);
            end
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic e1, input logic [4:0] a1,
                         input logic e2, input logic [4:0] a2,
                         input logic [31:0] x1, input logic [31:0] x2, input string nm);
        sb_entry_t e;
        reset    = rst;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_en1   = e1;
        rd_addr1 = a1;
        rd_en2   = e2;
        rd_addr2 = a2;
        e.name = nm;
        e.exp1 = x1;
        e.exp2 = x2;
        sb_q.push_back(e);
        #1;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic e1, input logic [4:0] a1,
                                input logic e2, input logic [4:0] a2,
                                input logic [31:0] x1, input logic [31:0] x2, input logic ca);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.e1 = e1; v.a1 = a1; v.e2 = e2; v.a2 = a2;
        v.x1 = x1; v.x2 = x2; v.clk_after = ca;
        return v;
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        vecs.push_back(mk(1, 5'd3,  32'h3,        1, 5'd3,  1, 5'd4,  32'h3,        32'hA5A50004, 1));
        vecs.push_back(mk(1, 5'd4,  32'h4,        1, 5'd4,  1, 5'd3,  32'h4,        32'h3,        1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd3,  1, 5'd4,  32'h3,        32'h4,        0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd4,  1, 5'd3,  32'h4,        32'h3,        0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd3,  0, 5'd4,  32'h3,        32'h0,        0));
        vecs.push_back(mk(1, 5'd0,  32'hDEADBEEF, 1, 5'd0,  1, 5'd0,  32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd0,  1, 5'd0,  32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 5'd7,  32'h11,       1, 5'd7,  0, 5'd7,  32'h11,       32'h0,        1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd7,  1, 5'd7,  32'h11,       32'h11,       0));
        vecs.push_back(mk(1, 5'd7,  32'hCAFEF00D, 1, 5'd7,  1, 5'd7,  32'hCAFEF00D, 32'hCAFEF00D, 1));
        vecs.push_back(mk(0, 5'd7,  32'h0,        1, 5'd7,  1, 5'd7,  32'hCAFEF00D, 32'hCAFEF00D, 0));
        vecs.push_back(mk(1, 5'd8,  32'h1,        1, 5'd9,  1, 5'd8,  32'hA5A50009, 32'h1,        1));
        vecs.push_back(mk(0, 5'd9,  32'hFFFFFFFF, 1, 5'd9,  1, 5'd8,  32'hA5A50009, 32'h1,        0));
        vecs.push_back(mk(1, 5'd10, 32'h111,      1, 5'd10, 0, 5'd0,  32'h111,      32'h0,        1));
        vecs.push_back(mk(1, 5'd10, 32'h222,      0, 5'd10, 1, 5'd10, 32'h0,        32'h222,      1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd10, 1, 5'd31, 32'h222,      32'hA5A5001F, 0));
        vecs.push_back(mk(1, 5'd11, 32'hBB,       0, 5'd11, 1, 5'd11, 32'h0,        32'hBB,       1));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd11, 1, 5'd1,  32'hBB,       32'hA5A50001, 0));

        // x0 reads zero even before any reset
        drive(0, 0, 5'd0, 32'h0, 1, 5'd0, 1, 5'd0, 32'h0, 32'h0, "pre_reset_x0");

        // Reset: every register reads 0 afterwards; bypass still live during reset
        drive(1, 1, 5'd6, 32'h66, 1, 5'd6, 1, 5'd0, 32'h66, 32'h0, "bypass_during_reset");
        tick();
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(31 - i), 32'h0, 32'h0, $sformatf("reset_state_x%0d", i));
        end

        // Reset clear after a write
        drive(0, 1, 5'd5, 32'h12345678, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0, "write_x5");
        tick();
        drive(0, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd0, 32'h12345678, 32'h0, "x5_stored");
        drive(1, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd0, 32'h12345678, 32'h0, "x5_before_reset_edge");
        tick();
        drive(0, 0, 5'd0, 32'h0, 1, 5'd5, 0, 5'd0, 32'h0, 32'h0, "reset_clear_x5");

        // Write all, bypass visible in the write cycle
        for (int i = 1; i < 32; i++) begin
            drive(0, 1, 5'(i), 32'hA5A50000 | 32'(i), 1, 5'(i), 0, 5'(i),
                  32'hA5A50000 | 32'(i), 32'h0, $sformatf("write_bypass_x%0d", i));
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            logic [31:0] x;
            x = (i == 0) ? 32'h0 : (32'hA5A50000 | 32'(i));
            drive(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(i), x, x, $sformatf("read_all_x%0d", i));
        end
        drive(0, 0, 5'd0, 32'h0, 0, 5'd12, 0, 5'd13, 32'h0, 32'h0, "read_disabled");

        // Table-driven vectors
        for (int k = 0; k < vecs.size(); k++) begin
            drive(0, vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].e1, vecs[k].a1,
                  vecs[k].e2, vecs[k].a2, vecs[k].x1, vecs[k].x2, $sformatf("vec_%0d", k));
            if (vecs[k].clk_after) tick();
        end

        // Reset vs write collision: reset wins for storage, bypass still shows data
        drive(1, 1, 5'd9, 32'hFFFFFFFF, 1, 5'd9, 1, 5'd3, 32'hFFFFFFFF, 32'h3, "collision_bypass");
        tick();
        drive(0, 0, 5'd0, 32'h0, 1, 5'd9, 1, 5'd3, 32'h0, 32'h0, "collision_x9_cleared");
        drive(0, 0, 5'd0, 32'h0, 1, 5'd7, 1, 5'd31, 32'h0, 32'h0, "collision_others_cleared");

        if (sb_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_leftover: %0d entries remain, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
